// File: rtl/bcd_xs3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_xs3_seq_ctrl
//
// Converts a packed multi-digit BCD word to Excess-3. It converts one digit per
// clock through a single shared 4-bit BCD->XS3 gate network. A valid/ready
// handshake sits on each side, and only one word is in flight at a time.
//
// Sequence: IDLE accepts a word. CONV then converts digit digit_idx on each
// cycle, least significant digit first, for DIGITS cycles. DONE holds the
// result until the consumer takes it.
//
// Ports
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_valid   in   1          producer presents in_bcd
//   in_ready   out  1          block can accept a word (IDLE only)
//   in_bcd     in   4*DIGITS   packed BCD, digit 0 = bits [3:0]
//   out_valid  out  1          out_xs3 holds a completed word (DONE)
//   out_ready  in   1          consumer accepts out_xs3
//   out_xs3    out  4*DIGITS   packed Excess-3 result, digit 0 = bits [3:0]
//   busy       out  1          conversion in progress (CONV)
//   digit_idx  out  IDX_W      digit being converted (meaningful while busy)
//   err        out  1          invalid-digit flag for the current word
//
// Optional feature macro: XS3_INVALID_CHECK_EN
//   Defined:   a digit > 9 forces its output nibble to 4'hF and sets err.
//              err stays set for that word and clears on the next accept.
//   Undefined: invalid digits pass through the gate equations unchanged,
//              and err is tied to 0.
// ---------------------------------------------------------------------------
module bcd_xs3_seq_ctrl #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_bcd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_xs3,
    output logic                  busy,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CONV = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [1:0]          state_q,   state_d;
    logic [4*DIGITS-1:0] srcWord_q, srcWord_d;
    logic [4*DIGITS-1:0] result_q,  result_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;

    logic [3:0] curBcd;
    logic [3:0] gateXs3;
    logic [3:0] nibbleOut;
    logic       gateW;
    logic       accept;

    // The active digit is selected from the latched source word by idx_q.
    // {idx_q, 2'b00} equals idx_q*4 and gives the nibble base bit.
    always_comb begin
        curBcd = srcWord_q[{idx_q, 2'b00} +: 4];
    end

    // This is the shared BCD->XS3 gate network. For b = 0..9 it yields b + 3.
    always_comb begin
        gateW      = curBcd[1] | curBcd[0];
        gateXs3[0] = ~curBcd[0];
        gateXs3[1] = ~(curBcd[1] ^ curBcd[0]);
        gateXs3[2] = curBcd[2] ^ gateW;
        gateXs3[3] = curBcd[3] | (curBcd[2] & gateW);
    end

`ifdef XS3_INVALID_CHECK_EN
    logic err_q, err_d;
    logic digitInvalid;

    // When the check is enabled, digits above 9 produce 4'hF.
    always_comb begin
        digitInvalid = (curBcd > 4'd9);
        nibbleOut    = digitInvalid ? 4'hF : gateXs3;
    end
`else
    // When the check is disabled, invalid digits go through the gates unchanged.
    always_comb begin
        nibbleOut = gateXs3;
    end
`endif

    assign accept = (state_q == ST_IDLE) && in_valid;

    // This block holds the next-state logic for the sequencer. An accept latches
    // the source word and clears the result. Each CONV cycle writes one result
    // nibble. DONE waits for the output handshake.
    always_comb begin
        state_d   = state_q;
        srcWord_d = srcWord_q;
        result_d  = result_q;
        idx_d     = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    srcWord_d = in_bcd;
                    result_d  = '0;
                    idx_d     = '0;
                    state_d   = ST_CONV;
                end
            end
            ST_CONV: begin
                result_d[{idx_q, 2'b00} +: 4] = nibbleOut;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // These are the state registers. Reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            srcWord_q <= '0;
            result_q  <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            srcWord_q <= srcWord_d;
            result_q  <= result_d;
            idx_q     <= idx_d;
        end
    end

`ifdef XS3_INVALID_CHECK_EN
    // The error flag clears on each accept and stays set through DONE once
    // any digit of the word is invalid.
    always_comb begin
        err_d = err_q;
        if (accept) begin
            err_d = 1'b0;
        end else if ((state_q == ST_CONV) && digitInvalid) begin
            err_d = 1'b1;
        end
    end

    // This is the error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_CONV);
    assign out_valid = (state_q == ST_DONE);
    assign out_xs3   = result_q;
    assign digit_idx = idx_q;

endmodule

// File: tb/tb_bcd_xs3_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_xs3_seq_ctrl
//
// This is the self-checking bench for bcd_xs3_seq_ctrl with DIGITS = 4.
//
// A reference model tracks the phase of the current word: idle, conversion
// step, or done. It computes the expected word from the digit rules: b + 3
// for valid digits, plus the gate result or 4'hF for invalid ones.
//
// A compare process checks the DUT against the model on every falling edge.
// Directed sequences pin literal results. A randomized phase drives random
// words and handshakes.
// ---------------------------------------------------------------------------
module tb_bcd_xs3_seq_ctrl;

    localparam int DIGITS = 4;
    localparam int IDX_W  = 2;
    localparam int PHASE_IDLE = -1;
    localparam int PHASE_DONE = DIGITS;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_xs3;
    logic              busy;
    logic [IDX_W-1:0]  digit_idx;
    logic              err;

    int vectors;
    int miscompares;
    bit checkEn;

    int          mPhase;
    logic [15:0] mWord;
    logic        mErr;

    bcd_xs3_seq_ctrl #(.DIGITS(DIGITS), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_xs3   (out_xs3),
        .busy      (busy),
        .digit_idx (digit_idx),
        .err       (err)
    );

    // This block generates a free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // This function gives the expected Excess-3 word. Valid digits map to
    // b + 3. Invalid digits map to 4'hF when the check is enabled; otherwise
    // they take the gate-network values computed by hand for 10..15.
    function automatic logic [15:0] xs3Word(input logic [15:0] w);
        logic [15:0] r;
        logic [3:0]  b;
        logic [3:0]  x;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            b = w[4*i +: 4];
            if (b <= 4'd9) begin
                x = b + 4'd3;
            end else begin
`ifdef XS3_INVALID_CHECK_EN
                x = 4'hF;
`else
                case (b)
                    4'hA:    x = 4'hD;
                    4'hB:    x = 4'hE;
                    4'hC:    x = 4'hF;
                    4'hD:    x = 4'h8;
                    4'hE:    x = 4'h9;
                    default: x = 4'hA;
                endcase
`endif
            end
            r[4*i +: 4] = x;
        end
        return r;
    endfunction

    // This function gives the expected err value for a word.
    function automatic logic xs3Err(input logic [15:0] w);
        logic e;
        e = 1'b0;
`ifdef XS3_INVALID_CHECK_EN
        for (int i = 0; i < DIGITS; i++) begin
            if (w[4*i +: 4] > 4'd9) e = 1'b1;
        end
`else
        if (w == 16'hFFFF) e = 1'b0;
`endif
        return e;
    endfunction

    // This task compares one value and records the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // The reference model tracks each word by its phase: idle, conversion
    // step 0..DIGITS-1, or done.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase <= PHASE_IDLE;
            mWord  <= '0;
            mErr   <= 1'b0;
        end else if (mPhase == PHASE_IDLE) begin
            if (in_valid) begin
                mPhase <= 0;
                mWord  <= xs3Word(in_bcd);
                mErr   <= xs3Err(in_bcd);
            end
        end else if (mPhase == PHASE_DONE) begin
            if (out_ready) mPhase <= PHASE_IDLE;
        end else begin
            mPhase <= mPhase + 1;
        end
    end

    // This process compares DUT outputs with the model on every falling edge
    // while reset is released.
    always @(negedge clk) begin
        if (checkEn && rst_n) begin
            checkOutput("in_ready", in_ready, mPhase == PHASE_IDLE);
            checkOutput("busy", busy, (mPhase >= 0) && (mPhase < DIGITS));
            checkOutput("out_valid", out_valid, mPhase == PHASE_DONE);
            if ((mPhase >= 0) && (mPhase < DIGITS)) begin
                checkOutput("digit_idx", digit_idx, mPhase);
            end
            if (mPhase == PHASE_DONE) begin
                checkOutput("out_xs3", out_xs3, mWord);
                checkOutput("err", err, mErr);
            end
        end
    end

    // This task waits for in_ready, then presents one word for a single
    // accepting edge.
    task automatic applyStimulus(input logic [15:0] word);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_bcd   = word;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_bcd   = $urandom;
    endtask

    // This task waits for out_valid within a bounded number of cycles. It
    // returns the number of edges it took, or -1 on timeout.
    task automatic waitValid(output int edges);
        edges = -1;
        for (int k = 1; k <= 40; k++) begin
            if (out_valid) begin
                edges = k - 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (edges < 0 && out_valid) edges = 40;
        if (edges < 0) checkOutput("out_valid_timeout", 0, 1);
    endtask

    // This is the stimulus: directed scenarios, then random traffic.
    initial begin
        int edges;
        logic [15:0] w;
        logic [15:0] e;
        vectors     = 0;
        miscompares = 0;
        checkEn     = 1'b0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_bcd      = '0;
        out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_digit_idx", digit_idx, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_out_xs3", out_xs3, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_in_ready", in_ready, 1);
        checkEn = 1'b1;

        // Scenario 1: 1234 -> 4567. The accepting edge counts as edge 1, so
        // out_valid appears after the 5th edge.
        applyStimulus(16'h1234);
        waitValid(edges);
        checkOutput("latency_edges", edges + 1, DIGITS + 1);
        checkOutput("t1_out_xs3", out_xs3, 16'h4567);
        checkOutput("t1_err", err, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Scenario 2: 0000 and 9999 back to back with out_ready held at 1.
        applyStimulus(16'h0000);
        waitValid(edges);
        checkOutput("t2a_out_xs3", out_xs3, 16'h3333);
        applyStimulus(16'h9999);
        waitValid(edges);
        checkOutput("t2b_out_xs3", out_xs3, 16'hCCCC);
        @(posedge clk); #1;

        // Scenario 3: backpressure for 3 cycles while in_valid pulses.
        out_ready = 1'b0;
        applyStimulus(16'h2468);
        waitValid(edges);
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            in_bcd   = 16'h7777;
            @(posedge clk); #1;
            in_valid = 1'b0;
            checkOutput("t3_hold_valid", out_valid, 1);
            checkOutput("t3_hold_xs3", out_xs3, 16'h579B);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("t3_back_idle", in_ready, 1);

        // Scenario 4: reset in mid-conversion at digit_idx 2.
        applyStimulus(16'h8888);
        edges = 0;
        while (!(busy && digit_idx == 2'd2) && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        checkOutput("t4_reached_idx2", digit_idx, 2);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("t4_rst_out_valid", out_valid, 0);
        checkOutput("t4_rst_busy", busy, 0);
        checkOutput("t4_rst_out_xs3", out_xs3, 0);
        checkOutput("t4_rst_digit_idx", digit_idx, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h0501);
        waitValid(edges);
        checkOutput("t4_out_xs3", out_xs3, 16'h3834);

        // Scenario 5: a word containing an invalid digit.
        applyStimulus(16'h12A4);
        waitValid(edges);
`ifdef XS3_INVALID_CHECK_EN
        checkOutput("t5_out_xs3", out_xs3, 16'h45F7);
        checkOutput("t5_err", err, 1);
`else
        checkOutput("t5_out_xs3", out_xs3, 16'h45D7);
        checkOutput("t5_err", err, 0);
`endif

        // Scenario 6: a single digit 0..9 in every position, with the other
        // digits at zero (which maps to 3).
        for (int p = 0; p < DIGITS; p++) begin
            for (int v = 0; v < 10; v++) begin
                w = 16'(v) << (4 * p);
                e = 16'h3333;
                e[4*p +: 4] = 4'(v + 3);
                applyStimulus(w);
                waitValid(edges);
                checkOutput("t6_out_xs3", out_xs3, e);
            end
        end

        // Random traffic: random words (some digits invalid) and random
        // valid/ready activity.
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            for (int d = 0; d < DIGITS; d++) begin
                in_bcd[4*d +: 4] = ($urandom_range(0, 9) == 0) ?
                                   4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        checkEn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
